// File: rtl/latch_bist_pkg.sv
// latch_bist_pkg: shared types and the fixed step table for the latch self-test.
package latch_bist_pkg;
    localparam int NUM_STEPS = 8;
    localparam int STEP_W    = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic d;
        logic e;
        logic exp_q;
    } step_t;

    // One {d,e,exp_q} entry per step; step 0 sits in the low bits.
    localparam logic [NUM_STEPS*3-1:0] STEP_TABLE = {
        3'b100,  // 7: hold, stays 0
        3'b010,  // 6: reset
        3'b001,  // 5: hold, stays 1
        3'b101,  // 4: hold, stays 1
        3'b111,  // 3: set
        3'b100,  // 2: hold, stays 0
        3'b000,  // 1: hold, stays 0
        3'b010   // 0: clear to a known state
    };
endpackage

// File: rtl/latch_bist_seq_rom.sv
// latch_bist_seq_rom: combinational lookup of the stimulus/expectation for a step.
//   step_i  : step index
//   entry_o : {d, e, exp_q} for that step
module latch_bist_seq_rom
    import latch_bist_pkg::*;
(
    input  logic [STEP_W-1:0] step_i,
    output step_t             entry_o
);
    assign entry_o = STEP_TABLE[3*step_i +: 3];
endmodule

// File: rtl/latch_bist.sv
// latch_bist: walks a D-latch through an 8-step set/reset/hold sequence and reports the result.
//   clk_i, rstn_i          : clock, synchronous active-low reset
//   start_i                : start request, honoured only when idle or done
//   latch_d_o, latch_e_o   : registered drive to the latch under test
//   latch_q_i, latch_nq_i  : latch outputs, sampled after the settle window
//   busy_o, done_o, pass_o : run status; pass_o is valid while done_o is high
//   fail_step_o, fail_obs_o: first failing step and the {Q,nQ} seen there
module latch_bist
    import latch_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              start_i,
    output logic              latch_d_o,
    output logic              latch_e_o,
    input  logic              latch_q_i,
    input  logic              latch_nq_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [STEP_W-1:0] fail_step_o,
    output logic [1:0]        fail_obs_o
);
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_cfg_err
        $error("latch_bist: SETTLE_CYCLES must be 1..255");
    end

    state_e            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              d_q, d_d, e_q, e_d;
    logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [STEP_W-1:0] fail_step_q, fail_step_d;
    logic [1:0]        fail_obs_q, fail_obs_d;
    step_t             entry;
    logic              match;

    latch_bist_seq_rom u_rom (
        .step_i  (step_q),
        .entry_o (entry)
    );

    // An X/Z on Q or nQ leaves match unknown, which the if below treats as a mismatch.
    assign match = (latch_q_i == entry.exp_q) && (latch_nq_i == ~latch_q_i);

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        cnt_d       = cnt_q;
        d_d         = d_q;
        e_d         = e_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_step_d = fail_step_q;
        fail_obs_d  = fail_obs_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d     = ST_APPLY;
                    step_d      = '0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    fail_step_d = '0;
                    fail_obs_d  = '0;
                end
            end
            ST_APPLY: begin
                d_d     = entry.d;
                e_d     = entry.e;
                cnt_d   = 8'(SETTLE_CYCLES - 1);
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q != '0) cnt_d = cnt_q - 8'd1;
                else             state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (match) begin
                    if (step_q == STEP_W'(NUM_STEPS - 1)) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        step_d  = step_q + 1'b1;
                        state_d = ST_APPLY;
                    end
                end else begin
                    // Drop enable so the latch holds whatever state exposed the fault.
                    state_d     = ST_DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    pass_d      = 1'b0;
                    fail_step_d = step_q;
                    fail_obs_d  = {latch_q_i, latch_nq_i};
                    e_d         = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            step_q      <= '0;
            cnt_q       <= '0;
            d_q         <= 1'b0;
            e_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_step_q <= '0;
            fail_obs_q  <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            cnt_q       <= cnt_d;
            d_q         <= d_d;
            e_q         <= e_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_step_q <= fail_step_d;
            fail_obs_q  <= fail_obs_d;
        end
    end

    assign latch_d_o   = d_q;
    assign latch_e_o   = e_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign fail_step_o = fail_step_q;
    assign fail_obs_o  = fail_obs_q;
endmodule
